// File: rtl/vga_plot_arbiter.sv
// Two-requester round-robin pixel arbiter in front of a VGA adapter write port,
// with a full-screen clear sweep that takes priority over pixel requests.
module vga_plot_arbiter #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 9,
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    input  logic [1:0]    req,
    input  logic [XW-1:0] rq0_x,
    input  logic [YW-1:0] rq0_y,
    input  logic [CW-1:0] rq0_c,
    input  logic [XW-1:0] rq1_x,
    input  logic [YW-1:0] rq1_y,
    input  logic [CW-1:0] rq1_c,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          clear_done,
    output logic          drop,
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic [CW-1:0] VGA_COLOR,
    output logic          plot
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(XMAX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(YMAX - 1);
    localparam logic [XW:0]   X_LIM  = (XW + 1)'(XMAX);
    localparam logic [YW:0]   Y_LIM  = (YW + 1)'(YMAX);

    state_t        state_q, state_d;
    logic [XW-1:0] cnt_x_q, cnt_x_d;
    logic [YW-1:0] cnt_y_q, cnt_y_d;
    logic [XW-1:0] vga_x_q, vga_x_d;
    logic [YW-1:0] vga_y_q, vga_y_d;
    logic [CW-1:0] vga_c_q, vga_c_d;
    logic          plot_q, plot_d;
    logic          drop_q, drop_d;
    logic          last_q, last_d;

    logic          win;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [CW-1:0] sel_c;
    logic          at_end;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    always_comb begin
        state_d    = state_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        vga_c_d    = vga_c_q;
        plot_d     = 1'b0;
        drop_d     = 1'b0;
        last_d     = last_q;
        gnt        = 2'b00;
        clear_done = 1'b0;
        win        = 1'b0;
        sel_x      = rq0_x;
        sel_y      = rq0_y;
        sel_c      = rq0_c;
        at_end     = (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);
        nx         = cnt_x_q + 1'b1;
        ny         = cnt_y_q;
        if (cnt_x_q == X_LAST) begin
            nx = '0;
            ny = cnt_y_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    // The first sweep pixel is loaded on entry so the output
                    // registers always show the position the counters hold.
                    state_d = CLEAR;
                    cnt_x_d = '0;
                    cnt_y_d = '0;
                    vga_x_d = '0;
                    vga_y_d = '0;
                    vga_c_d = clear_color;
                    plot_d  = 1'b1;
                end else if (|req) begin
                    win    = (req == 2'b11) ? ~last_q : req[1];
                    gnt    = win ? 2'b10 : 2'b01;
                    last_d = win;
                    if (win) begin
                        sel_x = rq1_x;
                        sel_y = rq1_y;
                        sel_c = rq1_c;
                    end
                    if (({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM)) begin
                        vga_x_d = sel_x;
                        vga_y_d = sel_y;
                        vga_c_d = sel_c;
                        plot_d  = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                clear_done = at_end;
                if (at_end) begin
                    state_d = IDLE;
                end else begin
                    cnt_x_d = nx;
                    cnt_y_d = ny;
                    vga_x_d = nx;
                    vga_y_d = ny;
                    plot_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!Resetn) gnt = 2'b00;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            vga_x_q <= '0;
            vga_y_q <= '0;
            vga_c_q <= '0;
            plot_q  <= 1'b0;
            drop_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            vga_x_q <= vga_x_d;
            vga_y_q <= vga_y_d;
            vga_c_q <= vga_c_d;
            plot_q  <= plot_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign drop      = drop_q;
    assign plot      = plot_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_c_q;

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 SHALL have parameter XW, default 8, the VGA_X width (160x120 mode).
REQ-002 SHALL have parameter YW, default 7, the VGA_Y width.
REQ-003 SHALL have parameter CW, default 9, the VGA_COLOR width (COLOR_DEPTH).
REQ-004 SHALL have parameter XMAX, default 160, the screen width in pixels.
REQ-005 SHALL have parameter YMAX, default 120, the screen height in pixels.
REQ-006 SHALL have port CLOCK_50  in  1  system clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port Resetn  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port clear_req  in  1  request to fill the whole screen.
REQ-009 SHALL have port clear_color  in  CW  fill colour, sampled when clear_req is accepted.
REQ-010 SHALL have port req  in  2  per-requester pixel-valid bits.
REQ-011 SHALL have ports rq0_x/rq1_x  in  XW, rq0_y/rq1_y  in  YW, rq0_c/rq1_c  in  CW  pixel coordinates and colour per requester.
REQ-012 SHALL have port gnt  out  2  combinational per-requester ready.
REQ-013 SHALL have port busy  out  1  high while a clear is in progress.
REQ-014 SHALL have port clear_done  out  1  one-cycle pulse.
REQ-015 SHALL have port drop  out  1  one-cycle pulse flagging an out-of-range pixel.
REQ-016 SHALL have ports VGA_X  out  XW, VGA_Y  out  YW, VGA_COLOR  out  CW, plot  out  1, all registered, driving the VGA adapter write port.

Function
REQ-017 SHALL implement an FSM with states IDLE and CLEAR.
REQ-018 IDLE with clear_req=1: gnt SHALL be 00; on the next edge the FSM enters CLEAR, clears the x/y counters to 0 and latches clear_color.
REQ-019 IDLE with clear_req=0: gnt SHALL be one-hot for the arbitration winner when any req bit is high, else 00.
REQ-020 A transfer SHALL occur on an edge where req[i]=1 and gnt[i]=1; the requester holds its data until that edge.
REQ-021 Arbitration SHALL be round-robin: if only one requester is active it wins; if both are active, the requester not served last wins.
REQ-022 The last-served pointer SHALL update only on a transfer.
REQ-023 The edge after a transfer, VGA_X/VGA_Y/VGA_COLOR SHALL carry the winner's pixel with plot=1 (latency 1).
REQ-024 In any cycle with no transfer and no clear pixel, plot SHALL be 0 and VGA_X/VGA_Y/VGA_COLOR SHALL hold their previous values.
REQ-025 A transfer with x>=XMAX or y>=YMAX SHALL be accepted (gnt asserted) but produce plot=0 and a drop pulse the following cycle.
REQ-026 In CLEAR, each cycle SHALL output the current counter position with the latched colour and plot=1.
REQ-027 In CLEAR, x SHALL increment each cycle; at XMAX-1, x wraps to 0 and y increments; the sweep is row-major.
REQ-028 A full clear SHALL take exactly XMAX*YMAX plot cycles.
REQ-029 clear_done SHALL pulse in the same cycle as the plot of (XMAX-1, YMAX-1); the FSM returns to IDLE on the following edge.
REQ-030 busy SHALL be 1 from the first clear plot cycle through the clear_done cycle inclusive.
REQ-031 In CLEAR, gnt SHALL be 00 and clear_req SHALL be ignored.
REQ-032 clear_req and req asserted in the same IDLE cycle: clear SHALL win and no grant is issued.
REQ-033 The first IDLE cycle after clear_done SHALL arbitrate normally.

Reset
REQ-034 With Resetn=0 at an edge, the following SHALL be forced: state IDLE, counters 0, VGA_X/VGA_Y/VGA_COLOR=0, plot=0, busy=0, clear_done=0, drop=0, last-served pointer=1 (requester 0 wins first).
REQ-035 Reset asserted mid-clear SHALL abort the sweep; no further clear pixels are plotted.
REQ-036 While Resetn=0, gnt SHALL be 00.

Verification
REQ-037 Single requester: req=01, rq0=(5,7,0x1FF) -> gnt=01 same cycle; next cycle VGA_X=5, VGA_Y=7, VGA_COLOR=0x1FF, plot=1.
REQ-038 Contention: req=11 held, each requester presenting a new pixel per grant, after reset -> gnt sequence 01,10,01,10; the plot stream alternates the sources.
REQ-039 Clear: clear_req pulse with clear_color=0x000 -> 19200 consecutive plot cycles covering (0,0)...(159,119) in row-major order; busy high throughout; clear_done coincides with (159,119).
REQ-040 Collision: clear_req=1 and req=01 in the same cycle -> gnt=00; req=01 is held through the clear and granted in the first IDLE cycle after clear_done.
REQ-041 Out of range: rq1=(160,0) -> gnt=10; next cycle plot=0, drop=1.
REQ-042 Reset at clear pixel 100 -> plot=0 from the next edge; no further clear pixels; the next single request is served normally.
